// File: rtl/sar_preamp_ctrl_pkg.sv
// sar_preamp_ctrl_pkg: shared types for the SAR preamp sequencer.
// Holds the FSM state enum, phase-timer width and channel-width helper.
package sar_preamp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        SAMPLE,
        EQ,
        AMP,
        LATCH,
        DECIDE,
        DONE
    } state_t;

    localparam int CNT_W = 4;

    function automatic int chw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// sar_phase_timer: loadable down-counter timing one sequencer phase.
// Ports: clk, rstn (sync, active-low), load, len (phase length), expire.
module sar_phase_timer
    import sar_preamp_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;

    // Loading len-1 makes a phase last exactly len cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= len - 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = (r_cnt == '0);

endmodule

// File: rtl/sar_preamp_ctrl.sv
// sar_preamp_ctrl: N-bit SAR sequencer for a preamp + latch comparator.
// Ports: clk, rstn, start, cmp in; pwdn, eq, latch, track, dac_code,
// dout, valid, busy, ch_sel out. All outputs are registered.
module sar_preamp_ctrl
    import sar_preamp_ctrl_pkg::*;
#(
    parameter int NBIT      = 8,
    parameter int NCH       = 1,
    parameter int WAKE_CYC  = 2,
    parameter int SAMP_CYC  = 4,
    parameter int EQ_CYC    = 1,
    parameter int AMP_CYC   = 2,
    parameter int PWDN_IDLE = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 cmp,
    output logic                 pwdn,
    output logic                 eq,
    output logic                 latch,
    output logic                 track,
    output logic [NBIT-1:0]      dac_code,
    output logic [NBIT-1:0]      dout,
    output logic                 valid,
    output logic                 busy,
    output logic [chw(NCH)-1:0]  ch_sel
);

    localparam int CHW = chw(NCH);
    localparam int KW  = $clog2(NBIT);

    if (NBIT < 2 || NBIT > 16) begin : g_bad_nbit
        $error("NBIT out of range 2..16");
    end
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("NCH out of range 1..8");
    end
    if (WAKE_CYC < 1 || WAKE_CYC > 15 || SAMP_CYC < 1 || SAMP_CYC > 15 ||
        EQ_CYC < 1 || EQ_CYC > 15 || AMP_CYC < 1 || AMP_CYC > 15) begin : g_bad_cyc
        $error("phase length out of range 1..15");
    end
    if (PWDN_IDLE != 0 && PWDN_IDLE != 1) begin : g_bad_pwdn
        $error("PWDN_IDLE must be 0 or 1");
    end

    state_t            r_state, w_state_nxt;
    logic [NBIT-1:0]   r_code, w_code_nxt;
    logic [NBIT-1:0]   r_dout, w_dout_nxt;
    logic [KW-1:0]     r_k, w_k_nxt;
    logic [CHW-1:0]    r_ch, w_ch_nxt;
    logic              r_pwdn, r_eq, r_latch, r_track, r_valid, r_busy;
    logic              w_pwdn, w_eq, w_latch, w_track, w_valid, w_busy;
    logic [CNT_W-1:0]  w_len;
    logic              w_load, w_expire;

    sar_phase_timer u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (w_load),
        .len    (w_len),
        .expire (w_expire)
    );

    // Timer restarts whenever a new phase is entered.
    assign w_load = (w_state_nxt != r_state);

    always_comb begin
        w_len = CNT_W'(1);
        case (w_state_nxt)
            WAKE:    w_len = CNT_W'(WAKE_CYC);
            SAMPLE:  w_len = CNT_W'(SAMP_CYC);
            EQ:      w_len = CNT_W'(EQ_CYC);
            AMP:     w_len = CNT_W'(AMP_CYC);
            default: w_len = CNT_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_dout_nxt  = r_dout;
        w_k_nxt     = r_k;
        w_ch_nxt    = r_ch;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (PWDN_IDLE != 0) ? WAKE : SAMPLE;
                end
            end
            WAKE:   if (w_expire) w_state_nxt = SAMPLE;
            SAMPLE: if (w_expire) w_state_nxt = EQ;
            EQ:     if (w_expire) w_state_nxt = AMP;
            AMP:    if (w_expire) w_state_nxt = LATCH;
            LATCH:  w_state_nxt = DECIDE;
            DECIDE: begin
                w_code_nxt[r_k] = cmp;
                if (r_k != '0) begin
                    w_code_nxt[r_k - 1'b1] = 1'b1;
                    w_k_nxt     = r_k - 1'b1;
                    w_state_nxt = EQ;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_ch_nxt    = (r_ch == CHW'(NCH - 1)) ? '0 : r_ch + 1'b1;
                w_state_nxt = start ? SAMPLE : IDLE;
            end
        endcase
        // Each conversion starts its binary search from mid-scale.
        if (w_state_nxt == SAMPLE && r_state != SAMPLE) begin
            w_code_nxt = {1'b1, {(NBIT-1){1'b0}}};
            w_k_nxt    = KW'(NBIT - 1);
        end
        if (w_state_nxt == DONE) begin
            w_dout_nxt = w_code_nxt;
        end
        // Outputs follow the next state so they line up with it once registered.
        w_pwdn  = (w_state_nxt == IDLE) ? (PWDN_IDLE != 0) : 1'b0;
        w_eq    = !(w_state_nxt == AMP || w_state_nxt == LATCH);
        w_latch = (w_state_nxt == LATCH);
        w_track = (w_state_nxt == SAMPLE);
        w_valid = (w_state_nxt == DONE);
        w_busy  = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_code  <= '0;
            r_dout  <= '0;
            r_k     <= KW'(NBIT - 1);
            r_ch    <= '0;
            r_pwdn  <= 1'b1;
            r_eq    <= 1'b1;
            r_latch <= 1'b0;
            r_track <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_code  <= w_code_nxt;
            r_dout  <= w_dout_nxt;
            r_k     <= w_k_nxt;
            r_ch    <= w_ch_nxt;
            r_pwdn  <= w_pwdn;
            r_eq    <= w_eq;
            r_latch <= w_latch;
            r_track <= w_track;
            r_valid <= w_valid;
            r_busy  <= w_busy;
        end
    end

    assign pwdn     = r_pwdn;
    assign eq       = r_eq;
    assign latch    = r_latch;
    assign track    = r_track;
    assign dac_code = r_code;
    assign dout     = r_dout;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign ch_sel   = r_ch;

endmodule
